bram_program_loader: RTL
========================

# bram_program_loader

Byte-stream program loader that sits directly upstream of the CR16 top level's BRAM port B and CPU enable input. It receives a framed program image one byte at a time: a 16-bit length, then that many 16-bit words, then a 16-bit checksum. It writes the words into BRAM port B starting at address 0 and holds the processor disabled until a load completes with a matching checksum. The byte source is a serial receiver or a debug bridge using a valid/ready handshake.

## Interface
Parameters:
- P_DATA_WIDTH, 16, BRAM word width; fixed at 16 because the frame format carries 2 bytes per word.
- P_ADDRESS_WIDTH, 10, BRAM port B address width; image capacity is 2^P_ADDRESS_WIDTH words.

Ports:
- I_CLK  in  1  system clock; all state changes on its rising edge.
- I_NRESET  in  1  reset, synchronous, active-low.
- I_START  in  1  single-cycle request to begin a load.
- I_BYTE_VALID  in  1  source presents a byte on I_BYTE.
- I_BYTE  in  8  incoming byte.
- O_BYTE_READY  out  1  loader will accept a byte this cycle.
- O_BRAM_WRITE_ENABLE_B  out  1  write strobe to BRAM port B.
- O_BRAM_ADDRESS_B  out  P_ADDRESS_WIDTH  write address.
- O_BRAM_DATA_B  out  P_DATA_WIDTH  write data.
- O_CPU_ENABLE  out  1  drives the processor's enable input.
- O_BUSY  out  1  a load is in progress.
- O_DONE  out  1  the last load completed with a good checksum.
- O_ERROR  out  2  00 none, 01 length overflow, 10 checksum mismatch.

## Operation
- Handshake: a byte transfers only on a cycle with I_BYTE_VALID && O_BYTE_READY. All byte fields are big-endian (high byte first).
- O_BYTE_READY is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI and SUM_LO.
- IDLE: CPU enabled.
  - I_START → LEN_HI; clear the address counter, checksum accumulator and O_ERROR; drop O_CPU_ENABLE.
- LEN_HI → LEN_LO on transfer; the two bytes form the 16-bit word count N.
- LEN_LO on transfer:
  - N > 2^P_ADDRESS_WIDTH → ERROR with code 01. No BRAM writes occur.
  - N == 0 → SUM_HI.
  - Otherwise → DATA_HI; the remaining-word counter (P_ADDRESS_WIDTH+1 bits) is loaded with N.
- DATA_HI → DATA_LO on transfer; the high byte is latched.
- DATA_LO → WRITE on transfer; the word {hi, lo} is registered.
- WRITE lasts exactly one cycle:
  - O_BRAM_WRITE_ENABLE_B=1, with O_BRAM_ADDRESS_B=address counter and O_BRAM_DATA_B=word.
  - Checksum accumulator += word, mod 2^16.
  - Address counter increments and the remaining count decrements.
  - Next state: DATA_HI if the remaining count after decrement ≠ 0, else SUM_HI.
- SUM_HI → SUM_LO on transfer.
- SUM_LO on transfer: received sum == accumulator → DONE, else ERROR with code 10.
- DONE: O_DONE=1 and O_CPU_ENABLE=1.
- ERROR: O_CPU_ENABLE stays 0 and O_ERROR holds its code.
- I_START is honoured in IDLE, DONE and ERROR (restarts the load, clears O_DONE/O_ERROR). It is ignored in all other states.
- O_BUSY=1 in every state except IDLE, DONE and ERROR.
- The address counter wraps naturally. With N = 2^P_ADDRESS_WIDTH the last write goes to the all-ones address, and no write ever revisits address 0.
- Reset mid-load returns to IDLE. BRAM contents already written are left as-is; no rollback.

## Timing
- Reset values, applied on the first rising edge with I_NRESET=0:
  - state IDLE;
  - O_CPU_ENABLE=1, so the preloaded image runs;
  - O_BYTE_READY, O_BRAM_WRITE_ENABLE_B, O_BUSY and O_DONE = 0;
  - O_ERROR=00;
  - O_BRAM_ADDRESS_B and O_BRAM_DATA_B = 0.
- All outputs are registered or decoded from registered state; there is no combinational path from I_BYTE_VALID to O_BYTE_READY.
- After I_START: O_CPU_ENABLE=0, O_BUSY=1 and O_BYTE_READY=1 on the next cycle.
- Byte valid in the same cycle as I_START in IDLE: not accepted (ready is 0 that cycle).
- Each data word takes at least 3 cycles (hi, lo, write). O_BYTE_READY=0 in WRITE.
- The write strobe asserts the cycle after the low byte transfers.
- Minimum load time is 4 + 3N + 1 cycles at full source rate.
- DONE/ERROR outputs appear the cycle after the SUM_LO transfer.
- Stalls (I_BYTE_VALID=0) may last indefinitely. There is no timeout.

## Test plan
- Reset: hold I_NRESET=0 for 2 cycles → O_CPU_ENABLE=1, O_BUSY=0, O_ERROR=00, no write strobe.
- Good load:
  - Stimulus: I_START, then bytes 00 03 | 12 34 | AB CD | 00 01 | 14 01 (checksum 0x1234+0xABCD+0x0001 = 0xBE02).
  - The checksum does not match 0x1401 → ERROR, code 10.
  - Repeat the same load with trailer BE 02 → writes 0x1234@0, 0xABCD@1, 0x0001@2 as single-cycle strobes, then O_DONE=1 and O_CPU_ENABLE=1.
- Overflow: length 04 01 (1025) → ERROR code 01, zero write strobes, O_CPU_ENABLE=0. Length 04 00 is accepted and the final write lands at address 0x3FF.
- Empty image: 00 00 00 00 → DONE with no writes. 00 00 00 01 → ERROR code 10.
- Backpressure/stalls:
  - Drop I_BYTE_VALID randomly across a 2-word load → identical writes and outcome.
  - Present a byte during WRITE → it is not consumed until the next cycle.
  - I_START pulsed mid-load → ignored.
- Reset mid-load: assert reset after the first word is written → IDLE, O_CPU_ENABLE=1, word 0 remains in BRAM. A fresh I_START then loads correctly from address 0.

Source files
------------

// File: rtl/bram_program_loader.sv
// bram_program_loader
// Receives a framed program image as a big-endian byte stream
// (16-bit word count, that many 16-bit words, 16-bit checksum) and writes
// the words into BRAM port B from address 0 upward. The CPU is held
// disabled from the start of a load until a load finishes with a good
// checksum.
module bram_program_loader #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_START,
    input  logic                       I_BYTE_VALID,
    input  logic [7:0]                 I_BYTE,
    output logic                       O_BYTE_READY,
    output logic                       O_BRAM_WRITE_ENABLE_B,
    output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS_B,
    output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA_B,
    output logic                       O_CPU_ENABLE,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic [1:0]                 O_ERROR
);

    // Largest word count the BRAM can hold.
    localparam int unsigned C_CAPACITY = 2 ** P_ADDRESS_WIDTH;
    // Remaining-count value meaning "this write is the last one".
    localparam logic [P_ADDRESS_WIDTH:0] C_COUNT_LAST = (P_ADDRESS_WIDTH + 1)'(1);

    localparam logic [1:0] C_ERR_NONE     = 2'b00;
    localparam logic [1:0] C_ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] C_ERR_CHECKSUM = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_SUM_HI  = 4'd6,
        S_SUM_LO  = 4'd7,
        S_DONE    = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    // Running checksum: plain 16-bit wrap-around addition.
    function automatic logic [P_DATA_WIDTH-1:0] f_sum_add(
        input logic [P_DATA_WIDTH-1:0] acc,
        input logic [P_DATA_WIDTH-1:0] word
    );
        return acc + word;
    endfunction

    state_t                     state_r;
    state_t                     state_next_s;

    logic [7:0]                 len_hi_r;
    logic [7:0]                 data_hi_r;
    logic [7:0]                 sum_hi_r;
    logic [P_DATA_WIDTH-1:0]    word_r;
    logic [P_DATA_WIDTH-1:0]    sum_r;
    logic [P_ADDRESS_WIDTH-1:0] addr_r;
    logic [P_ADDRESS_WIDTH:0]   count_r;
    logic [1:0]                 error_r;

    logic                       byte_ready_r;
    logic                       bram_we_r;
    logic                       cpu_enable_r;
    logic                       busy_r;
    logic                       done_r;

    logic                       byte_ready_next_s;
    logic                       bram_we_next_s;
    logic                       cpu_enable_next_s;
    logic                       busy_next_s;
    logic                       done_next_s;

    logic                       xfer_s;
    logic [15:0]                len_word_s;
    logic [15:0]                rx_sum_s;
    logic                       len_overflow_s;
    logic                       len_zero_s;
    logic                       sum_match_s;
    logic                       start_ok_s;

    // Handshake and decoded views of the byte currently on the input.
    always_comb begin
        xfer_s         = I_BYTE_VALID && byte_ready_r;
        len_word_s     = {len_hi_r, I_BYTE};
        rx_sum_s       = {sum_hi_r, I_BYTE};
        len_overflow_s = 32'(len_word_s) > C_CAPACITY;
        len_zero_s     = (len_word_s == 16'd0);
        sum_match_s    = (rx_sum_s == sum_r);
        start_ok_s     = I_START && ((state_r == S_IDLE) || (state_r == S_DONE) ||
                                     (state_r == S_ERROR));
    end

    // State register.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: byte states advance only on a completed transfer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (I_START) begin
                    state_next_s = S_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    state_next_s = S_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LEN_LO: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (len_overflow_s) begin
                    state_next_s = S_ERROR;
                end else if (len_zero_s) begin
                    state_next_s = S_SUM_HI;
                end else begin
                    state_next_s = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer_s) begin
                    state_next_s = S_DATA_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_DATA_LO: begin
                if (xfer_s) begin
                    state_next_s = S_WRITE;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_WRITE: begin
                if (count_r == C_COUNT_LAST) begin
                    state_next_s = S_SUM_HI;
                end else begin
                    state_next_s = S_DATA_HI;
                end
            end
            S_SUM_HI: begin
                if (xfer_s) begin
                    state_next_s = S_SUM_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_SUM_LO: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (sum_match_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ERROR;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flops below present
    // each state's outputs during that state.
    always_comb begin
        byte_ready_next_s = 1'b0;
        bram_we_next_s    = 1'b0;
        cpu_enable_next_s = 1'b0;
        busy_next_s       = 1'b1;
        done_next_s       = 1'b0;
        case (state_next_s)
            S_IDLE: begin
                cpu_enable_next_s = 1'b1;
                busy_next_s       = 1'b0;
            end
            S_DONE: begin
                cpu_enable_next_s = 1'b1;
                busy_next_s       = 1'b0;
                done_next_s       = 1'b1;
            end
            S_ERROR: begin
                busy_next_s = 1'b0;
            end
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_SUM_HI, S_SUM_LO: begin
                byte_ready_next_s = 1'b1;
            end
            S_WRITE: begin
                bram_we_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Output registers; after reset the CPU runs the preloaded image.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            byte_ready_r <= 1'b0;
            bram_we_r    <= 1'b0;
            cpu_enable_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_next_s;
            bram_we_r    <= bram_we_next_s;
            cpu_enable_r <= cpu_enable_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    // Datapath: byte capture, word assembly, address/count and checksum.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            len_hi_r  <= 8'd0;
            data_hi_r <= 8'd0;
            sum_hi_r  <= 8'd0;
            word_r    <= '0;
            sum_r     <= '0;
            addr_r    <= '0;
            count_r   <= '0;
            error_r   <= C_ERR_NONE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_ok_s) begin
                        addr_r  <= '0;
                        sum_r   <= '0;
                        error_r <= C_ERR_NONE;
                    end
                end
                S_LEN_HI: begin
                    if (xfer_s) begin
                        len_hi_r <= I_BYTE;
                    end
                end
                S_LEN_LO: begin
                    if (xfer_s) begin
                        // Only meaningful when the length fits; unused otherwise.
                        count_r <= len_word_s[P_ADDRESS_WIDTH:0];
                        if (len_overflow_s) begin
                            error_r <= C_ERR_OVERFLOW;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (xfer_s) begin
                        data_hi_r <= I_BYTE;
                    end
                end
                S_DATA_LO: begin
                    if (xfer_s) begin
                        word_r <= {data_hi_r, I_BYTE};
                    end
                end
                S_WRITE: begin
                    sum_r   <= f_sum_add(sum_r, word_r);
                    addr_r  <= addr_r + P_ADDRESS_WIDTH'(1);
                    count_r <= count_r - (P_ADDRESS_WIDTH + 1)'(1);
                end
                S_SUM_HI: begin
                    if (xfer_s) begin
                        sum_hi_r <= I_BYTE;
                    end
                end
                S_SUM_LO: begin
                    if (xfer_s && !sum_match_s) begin
                        error_r <= C_ERR_CHECKSUM;
                    end
                end
                default: begin
                    error_r <= error_r;
                end
            endcase
        end
    end

    assign O_BYTE_READY          = byte_ready_r;
    assign O_BRAM_WRITE_ENABLE_B = bram_we_r;
    assign O_BRAM_ADDRESS_B      = addr_r;
    assign O_BRAM_DATA_B         = word_r;
    assign O_CPU_ENABLE          = cpu_enable_r;
    assign O_BUSY                = busy_r;
    assign O_DONE                = done_r;
    assign O_ERROR               = error_r;

endmodule
